// File: rtl/processor_pkg.sv
// Shared constants for the pipelined processor: opcodes, funct codes,
// ALU control encodings, the nop instruction and the decoded-control bundle.
package processor_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RAW   = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic     regwrite;
    logic     memtoreg;
    logic     memwrite;
    logic     branch;
    logic     alusrc;
    logic     regdst;
    alu_ctl_e aluctl;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two asynchronous read ports, one write port,
// r0 hardwired to zero, and write-through bypass from the write port.
module register_file
  import processor_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RAW-1:0]  ra1,
  input  logic [RAW-1:0]  ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RAW-1:0]  wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: cleared on reset, r0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[RAW'(i)] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Read port 1 with r0 forcing and same-cycle writeback bypass.
  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end
  end

  // Read port 2 with r0 forcing and same-cycle writeback bypass.
  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID register, register file, main decoder,
// beq resolution in ID and load-use / branch hazard detection.
// Optional feature macro: DECODE_BRANCH_FWD_EN (forward ALUOutM into the
// branch comparator instead of stalling on an ALU result sitting in MEM).
module decode_stage
  import processor_pkg::*;
#(
  parameter logic [31:0] RESET_PC4 = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] ALUOutM,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  output logic        write,
  output logic        hazardDetected,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic [4:0]  RdD,
  output logic [31:0] SignImmD,
  output logic        RegWriteD,
  output logic        MemtoRegD,
  output logic        MemWriteD,
  output logic        ALUSrcD,
  output logic        RegDstD,
  output logic [2:0]  ALUControlD,
  output logic        FlushE
);

  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pcplus4_d;
  logic [5:0]      op;
  logic [5:0]      funct;
  ctrl_t           ctrl;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            equal_d;
  logic            lwstall;
  logic            branchstall;
  logic            stall;
  logic [4:0]      unused_shamt;

  // True when a nonzero destination matches either source of the ID instruction.
  function automatic logic dep(input logic [4:0] dst, input logic [4:0] rs,
                               input logic [4:0] rt);
    return (dst != 5'd0) && ((dst == rs) || (dst == rt));
  endfunction

  // IF/ID register: hold on stall, squash on taken branch, otherwise advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d   <= NOP_INSTR;
      pcplus4_d <= RESET_PC4;
    end else if (!stall) begin
      instr_d   <= PCSrcD ? NOP_INSTR : InstrF;
      pcplus4_d <= PCPlus4F;
    end
  end

  assign op           = instr_d[31:26];
  assign funct        = instr_d[5:0];
  assign RsD          = instr_d[25:21];
  assign RtD          = instr_d[20:16];
  assign RdD          = instr_d[15:11];
  assign unused_shamt = instr_d[10:6];
  assign SignImmD     = {{16{instr_d[15]}}, instr_d[15:0]};

  register_file u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (RsD),
    .ra2   (RtD),
    .rd1   (RD1D),
    .rd2   (RD2D),
    .we    (RegWriteW),
    .wa    (WriteRegW),
    .wd    (ResultW)
  );

  // Main decoder; anything outside the supported set decodes as a nop.
  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.aluctl = ALU_ADD;
          FN_SUB:  ctrl.aluctl = ALU_SUB;
          FN_AND:  ctrl.aluctl = ALU_AND;
          FN_OR:   ctrl.aluctl = ALU_OR;
          FN_SLT:  ctrl.aluctl = ALU_SLT;
          default: ctrl = '0;
        endcase
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctl   = ALU_ADD;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctl   = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.aluctl = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctl   = ALU_ADD;
      end
      default: ctrl = '0;
    endcase
  end

  assign RegWriteD   = ctrl.regwrite;
  assign MemtoRegD   = ctrl.memtoreg;
  assign MemWriteD   = ctrl.memwrite;
  assign ALUSrcD     = ctrl.alusrc;
  assign RegDstD     = ctrl.regdst;
  assign ALUControlD = ctrl.aluctl;

  assign lwstall = MemtoRegE & dep(WriteRegE, RsD, RtD);

`ifdef DECODE_BRANCH_FWD_EN
  // Branch operands take the MEM-stage ALU result when it targets them.
  always_comb begin
    src_a = RD1D;
    src_b = RD2D;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD)) src_a = ALUOutM;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD)) src_b = ALUOutM;
  end

  assign branchstall = ctrl.branch &
                       ((RegWriteE & dep(WriteRegE, RsD, RtD)) |
                        (MemtoRegM & dep(WriteRegM, RsD, RtD)));
`else
  logic [31:0] unused_aluoutm;

  // Without forwarding the comparator reads only the register file.
  assign src_a          = RD1D;
  assign src_b          = RD2D;
  assign unused_aluoutm = ALUOutM;

  assign branchstall = ctrl.branch &
                       ((RegWriteE & dep(WriteRegE, RsD, RtD)) |
                        (MemtoRegM & dep(WriteRegM, RsD, RtD)) |
                        (RegWriteM & dep(WriteRegM, RsD, RtD)));
`endif

  assign stall          = lwstall | branchstall;
  assign equal_d        = (src_a == src_b);
  assign PCSrcD         = ctrl.branch & equal_d & ~stall;
  assign PCBranchD      = pcplus4_d + (SignImmD << 2);
  assign write          = ~stall;
  assign hazardDetected = stall;
  assign FlushE         = stall;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed test-plan sequences followed
// by randomized traffic, checked against a behavioural model of the stage.
module tb_decode_stage;

  localparam logic [31:0] RST_PC4 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrF, PCPlus4F, ALUOutM, ResultW;
  logic        RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        write, hazardDetected, PCSrcD, FlushE;
  logic [31:0] PCBranchD, RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       wr, hz, pcsrc, flush, rw, m2r, mw, asrc, rdst;
    logic [2:0] alu;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] pcb, rd1, rd2, simm;
    logic [14:0] regs;
  } exp_t;

  exp_t        q[$];
  exp_t        cur_exp;
  logic [31:0] m_instr, m_pc4;
  logic [31:0] m_regs [32];

  decode_stage #(.RESET_PC4(RST_PC4)) dut (
    .clk(clk), .rst_n(rst_n), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
    .ALUOutM(ALUOutM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .write(write), .hazardDetected(hazardDetected),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .RD1D(RD1D), .RD2D(RD2D),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .FlushE(FlushE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic uses(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return (d != 5'd0) && ((d == a) || (d == b));
  endfunction

  function automatic logic [31:0] rf(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && (WriteRegW == a)) return ResultW;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] bop(input logic [4:0] a);
`ifdef DECODE_BRANCH_FWD_EN
    if (RegWriteM && (a != 5'd0) && (WriteRegM == a)) return ALUOutM;
`endif
    return rf(a);
  endfunction

  function automatic exp_t model_out();
    exp_t        e;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic        is_r, is_lw, is_sw, is_beq, is_addi, m_extra, stall;
    logic [31:0] simm;
    op      = m_instr[31:26];
    fn      = m_instr[5:0];
    rs      = m_instr[25:21];
    rt      = m_instr[20:16];
    rd      = m_instr[15:11];
    simm    = {{16{m_instr[15]}}, m_instr[15:0]};
    is_r    = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2B);
    is_beq  = (op == 6'h04);
    is_addi = (op == 6'h08);
`ifdef DECODE_BRANCH_FWD_EN
    m_extra = 1'b0;
`else
    m_extra = RegWriteM && uses(WriteRegM, rs, rt);
`endif
    stall = (MemtoRegE && uses(WriteRegE, rs, rt)) ||
            (is_beq && ((RegWriteE && uses(WriteRegE, rs, rt)) ||
                        (MemtoRegM && uses(WriteRegM, rs, rt)) || m_extra));
    e          = '0;
    e.ctl.rw   = is_r || is_lw || is_addi;
    e.ctl.m2r  = is_lw;
    e.ctl.mw   = is_sw;
    e.ctl.asrc = is_lw || is_sw || is_addi;
    e.ctl.rdst = is_r;
    if (is_r) begin
      case (fn)
        6'h20:   e.ctl.alu = 3'b010;
        6'h22:   e.ctl.alu = 3'b110;
        6'h24:   e.ctl.alu = 3'b000;
        6'h25:   e.ctl.alu = 3'b001;
        default: e.ctl.alu = 3'b111;
      endcase
    end else if (is_beq) begin
      e.ctl.alu = 3'b110;
    end else if (is_lw || is_sw || is_addi) begin
      e.ctl.alu = 3'b010;
    end
    e.ctl.pcsrc = is_beq && (bop(rs) == bop(rt)) && !stall;
    e.ctl.wr    = !stall;
    e.ctl.hz    = stall;
    e.ctl.flush = stall;
    e.pcb       = m_pc4 + simm * 4;
    e.rd1       = rf(rs);
    e.rd2       = rf(rt);
    e.simm      = simm;
    e.regs      = {rs, rt, rd};
    return e;
  endfunction

  task automatic model_reset();
    m_instr = 32'd0;
    m_pc4   = RST_PC4;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  // Advance the model by one rising edge using this cycle's inputs.
  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (RegWriteW && (WriteRegW != 5'd0)) m_regs[WriteRegW] = ResultW;
      if (!cur_exp.ctl.hz) begin
        m_instr = cur_exp.ctl.pcsrc ? 32'd0 : InstrF;
        m_pc4   = PCPlus4F;
      end
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic commit();
    cur_exp = model_out();
    q.push_back(cur_exp);
  endtask

  task automatic idle();
    InstrF = 32'd0;   PCPlus4F = 32'd0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; WriteRegE = 5'd0;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = 5'd0; ALUOutM = 32'd0;
    RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    tick(); idle();
    RegWriteW = 1'b1; WriteRegW = a; ResultW = d;
    commit();
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'd9;
      2:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fl [5];
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    fl  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2, 3, 4: return {6'h00, rs, rt, rd, 5'd0, fl[$urandom_range(0, 4)]};
      5:  return {6'h23, rs, rt, imm};
      6:  return {6'h2B, rs, rt, imm};
      7:  return {6'h04, rs, rt, imm};
      8:  return {6'h04, rs, rs, imm};
      9:  return {6'h08, rs, rt, imm};
      10: return {6'h00, rs, rt, rd, 5'd0, 6'($urandom_range(0, 63))};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    ctl_t act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {write, hazardDetected, PCSrcD, FlushE, RegWriteD, MemtoRegD,
               MemWriteD, ALUSrcD, RegDstD, ALUControlD};
        chk("ctl",      32'(act), 32'(e.ctl));
        chk("pcbranch", PCBranchD, e.pcb);
        chk("rd1",      RD1D, e.rd1);
        chk("rd2",      RD2D, e.rd2);
        chk("regfld",   32'({RsD, RtD, RdD}), 32'(e.regs));
        chk("simm",     SignImmD, e.simm);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    cur_exp = '0;
    rst_n   = 1'b0;
    idle();
    model_reset();

    // Release reset between edges and look at the reset outputs.
    tick(); idle(); rst_n = 1'b1; commit();
    #1 chk("reset pcbranch", PCBranchD, RST_PC4);
    chk("reset write", 32'(write), 32'd1);
    chk("reset ctl", 32'({RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, FlushE, PCSrcD}), 32'd0);

    wr(5'd1, 32'd5); wr(5'd2, 32'd7); wr(5'd4, 32'h44);

    // add $3,$1,$2 with no hazard
    tick(); idle(); InstrF = 32'h0022_1820; PCPlus4F = 32'h8; commit();
    tick(); idle(); commit();
    #1 chk("add rd1", RD1D, 32'd5);
    chk("add rd2", RD2D, 32'd7);
    chk("add ctl", 32'({RegWriteD, RegDstD, ALUControlD, write}), 32'b11_010_1);

    // load-use: lw $2 in EX while add $3,$2,$4 is in ID
    tick(); idle(); InstrF = 32'h0044_1820; commit();
    tick(); idle(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2;
    InstrF = 32'h00A6_3820; commit();
    #1 chk("lu stall", 32'({write, hazardDetected, FlushE}), 32'b011);
    chk("lu rs", 32'(RsD), 32'd2);
    tick(); idle(); InstrF = 32'h00A6_3820; commit();
    #1 chk("lu after", 32'({write, hazardDetected, FlushE}), 32'b100);
    chk("lu held", 32'(RsD), 32'd2);

    // taken beq $1,$2,2 at PCPlus4D=0x10
    wr(5'd1, 32'd9); wr(5'd2, 32'd9);
    tick(); idle(); InstrF = 32'h1022_0002; PCPlus4F = 32'h10; commit();
    tick(); idle(); InstrF = 32'h0022_1820; PCPlus4F = 32'h14; commit();
    #1 chk("beq pcsrc", 32'(PCSrcD), 32'd1);
    chk("beq target", PCBranchD, 32'h18);
    tick(); idle(); commit();
    #1 chk("beq squash", 32'({RegWriteD, RsD, PCSrcD}), 32'd0);

    // writeback bypass and r0 protection
    tick(); idle(); InstrF = 32'h0080_2820; commit();
    tick(); idle(); RegWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'hDEAD; commit();
    #1 chk("bypass", RD1D, 32'hDEAD);
    tick(); idle(); RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'h1234; commit();
    #1 chk("r0 bypass", RD1D, 32'd0);

    // branch on an ALU result in MEM
    wr(5'd1, 32'd3);
    tick(); idle(); InstrF = 32'h1022_0002; PCPlus4F = 32'h40; commit();
    tick(); idle(); RegWriteM = 1'b1; WriteRegM = 5'd1; ALUOutM = 32'd9;
    InstrF = 32'h0022_1820; PCPlus4F = 32'h44; commit();
`ifdef DECODE_BRANCH_FWD_EN
    #1 chk("fwd nostall", 32'({write, PCSrcD}), 32'b11);
    chk("fwd target", PCBranchD, 32'h48);
`else
    #1 chk("nofwd stall", 32'({write, hazardDetected, PCSrcD}), 32'b010);
    tick(); idle(); RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'd9;
    InstrF = 32'h0022_1820; PCPlus4F = 32'h44; commit();
    #1 chk("nofwd resolve", 32'({write, PCSrcD}), 32'b11);
    chk("nofwd target", PCBranchD, 32'h48);
`endif

    // reset mid-run
    wr(5'd5, 32'h55);
    tick(); idle(); InstrF = 32'h00A5_1820; commit();
    tick(); idle(); InstrF = 32'h00A5_1820; commit();
    #1 chk("r5 set", RD1D, 32'h55);
    tick(); idle(); InstrF = 32'h00A5_1820;
    #1 rst_n = 1'b0; model_reset(); commit();
    #1 chk("rst instr", 32'({RsD, RtD, RdD}), 32'd0);
    chk("rst flags", 32'({write, PCSrcD, hazardDetected}), 32'b100);
    tick(); idle(); InstrF = 32'h00A5_1820; PCPlus4F = 32'h20; rst_n = 1'b1; commit();
    #1 chk("rst pcbranch", PCBranchD, RST_PC4);
    tick(); idle(); commit();
    #1 chk("r5 cleared", RD1D, 32'd0);
    chk("first capture", 32'(RsD), 32'd5);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      InstrF    = rand_instr();
      PCPlus4F  = $urandom & 32'hFFFF_FFFC;
      RegWriteE = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      WriteRegE = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom_range(0, 1));
      MemtoRegM = ($urandom_range(0, 3) == 0);
      WriteRegM = 5'($urandom_range(0, 7));
      ALUOutM   = rv();
      RegWriteW = ($urandom_range(0, 2) != 0);
      WriteRegW = 5'($urandom_range(0, 7));
      ResultW   = rv();
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
      end
      commit();
    end

    @(negedge clk);
    #1 chk("queue drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
